// File: rtl/dwt_level_arbiter.sv
// Round-robin arbiter sharing one 8-tap fp32 filter engine among DWT decomposition levels.
// Issues at most one beat per ISSUE_GAP cycles and routes in-order results back via a tag FIFO.
module dwt_level_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ISSUE_GAP = 4,
  parameter int TAG_DEPTH = 8,
  parameter int FLUSH_CYC = 16
) (
  input  logic                   clk_312_5,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*128-1:0]   req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   eng_valid,
  output logic [127:0]           eng_data,
  output logic [1:0]             eng_sel,
  input  logic                   eng_res_valid,
  input  logic [63:0]            eng_res,
  output logic [N_REQ-1:0]       res_valid,
  output logic [63:0]            res_data,
  output logic                   busy,
  output logic                   err_unexp
);

  localparam int CW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int FW = $clog2(FLUSH_CYC + 1);

  logic [CW-1:0]               cnt;
  logic [1:0]                  last_grant;
  logic [PW:0]                 wr_ptr, rd_ptr;
  logic [1:0]                  tag_mem [TAG_DEPTH];
  logic [FW-1:0]               flush;
  logic [N_REQ-1:0][127:0]     beat;
  logic [PW:0]                 occ;
  logic                        full, empty, found, xfer, pop, unexp;
  logic [1:0]                  gnt, idx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_beat
    assign beat[k] = req_data[128*k +: 128];
  end

  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == (PW+1)'(TAG_DEPTH));
  assign empty = (occ == '0);

  // Search starts one past the last winner so every level gets a turn.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = 2'((int'(last_grant) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    req_ready = '0;
    if (!rst && cnt == '0 && !full && found) req_ready[gnt] = 1'b1;
  end

  assign xfer  = |(req_valid & req_ready);
  // Results landing before the engine pipeline has drained are stale.
  assign pop   = eng_res_valid && !empty && (flush == '0);
  assign unexp = eng_res_valid &&  empty && (flush == '0);
  assign busy  = !empty || eng_valid;

  always_ff @(posedge clk_312_5) begin
    if (xfer) tag_mem[wr_ptr[PW-1:0]] <= gnt;
  end

  always_ff @(posedge clk_312_5 or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      last_grant <= 2'(N_REQ - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      flush      <= FW'(FLUSH_CYC);
      eng_valid  <= 1'b0;
      eng_data   <= '0;
      eng_sel    <= '0;
      res_valid  <= '0;
      res_data   <= '0;
      err_unexp  <= 1'b0;
    end else begin
      cnt       <= (cnt == CW'(ISSUE_GAP - 1)) ? '0 : cnt + 1'b1;
      if (flush != '0) flush <= flush - 1'b1;
      eng_valid <= xfer;
      if (xfer) begin
        last_grant <= gnt;
        eng_data   <= beat[gnt];
        eng_sel    <= gnt;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      res_valid <= '0;
      if (pop) begin
        res_valid <= N_REQ'(1) << tag_mem[rd_ptr[PW-1:0]];
        res_data  <= eng_res;
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (unexp) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dwt_level_arbiter.sv
// Directed bench for dwt_level_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_dwt_level_arbiter;
  localparam int N_REQ = 3, ISSUE_GAP = 4, TAG_DEPTH = 8, FLUSH_CYC = 16, LAT = 14;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ*128-1:0] req_data = '0;
  logic [N_REQ-1:0]     req_ready;
  logic                 eng_valid;
  logic [127:0]         eng_data;
  logic [1:0]           eng_sel;
  logic                 eng_res_valid;
  logic [63:0]          eng_res;
  logic [N_REQ-1:0]     res_valid;
  logic [63:0]          res_data;
  logic                 busy, err_unexp;

  // engine result source: automatic latency model or manual directed pulses
  logic        eng_auto = 1'b0, auto_v = 1'b0, man_v = 1'b0;
  logic [63:0] auto_d = '0, man_d = 64'hdead_0000_beef_0001;
  assign eng_res_valid = eng_auto ? auto_v : man_v;
  assign eng_res       = eng_auto ? auto_d : man_d;

  dwt_level_arbiter #(.N_REQ(N_REQ), .ISSUE_GAP(ISSUE_GAP), .TAG_DEPTH(TAG_DEPTH),
                      .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk_312_5(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .eng_valid(eng_valid), .eng_data(eng_data), .eng_sel(eng_sel),
    .eng_res_valid(eng_res_valid), .eng_res(eng_res), .res_valid(res_valid),
    .res_data(res_data), .busy(busy), .err_unexp(err_unexp));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int               m_cyc = 0, m_last = N_REQ - 1, pk;
  int               mq[$];
  logic             e_ev = 1'b0, m_err = 1'b0;
  logic [127:0]     e_ed = '0;
  logic [1:0]       e_es = '0;
  logic [N_REQ-1:0] e_rv = '0;
  logic [63:0]      e_rd = '0;

  function automatic int m_pick();
    int k;
    if (rst || (m_cyc % ISSUE_GAP) != 0 || mq.size() >= TAG_DEPTH) return -1;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (m_last + i) % N_REQ;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] m_ready();
    int p;
    p = m_pick();
    return (p < 0) ? '0 : N_REQ'(1) << p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0; m_last <= N_REQ - 1; mq.delete();
      e_ev <= 1'b0; e_ed <= '0; e_es <= '0; e_rv <= '0; e_rd <= '0; m_err <= 1'b0;
    end else begin
      pk = m_pick();
      e_rv <= '0;
      if (eng_res_valid && m_cyc >= FLUSH_CYC) begin
        if (mq.size() > 0) begin
          e_rv <= N_REQ'(1) << mq[0];
          e_rd <= eng_res;
          void'(mq.pop_front());
        end else m_err <= 1'b1;
      end
      e_ev <= (pk >= 0);
      if (pk >= 0) begin
        mq.push_back(pk);
        e_ed   <= req_data[128*pk +: 128];
        e_es   <= 2'(pk);
        m_last <= pk;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- engine latency model ----------------
  int tcyc = 0, eng_idx = 0;
  int eq_due[$], eq_idx[$];
  int iss_sel[1024];
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (eng_auto && eng_valid) begin
          eq_due.push_back(tcyc + LAT);
          eq_idx.push_back(eng_idx);
          iss_sel[eng_idx] = int'(eng_sel);
          eng_idx++;
        end
      end
      forever begin
        @(posedge clk);
        tcyc++;
        #1;
        if (!eng_auto) begin eq_due.delete(); eq_idx.delete(); end
        auto_v = 1'b0;
        if (eq_due.size() > 0 && eq_due[0] <= tcyc) begin
          auto_v = 1'b1;
          auto_d = 64'(eq_idx[0]);
          void'(eq_due.pop_front());
          void'(eq_idx.pop_front());
        end
      end
    join_none
  end

  // ---------------- checking and stimulus ----------------
  int   tot = 0, bad = 0, n_issue = 0, n_res = 0, nxt_res = 0, base = 0, base_res = 0;
  int   sel_log[$];
  logic chk_en = 1'b0, chk_route = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_cmp();
    logic [N_REQ-1:0] want_rv;
    chk("req_ready", 128'(req_ready), 128'(m_ready()));
    chk("eng_valid", 128'(eng_valid), 128'(e_ev));
    chk("eng_sel",   128'(eng_sel),   128'(e_es));
    chk("eng_data",  eng_data,        e_ed);
    chk("res_valid", 128'(res_valid), 128'(e_rv));
    chk("res_data",  128'(res_data),  128'(e_rd));
    chk("busy",      128'(busy),      128'(mq.size() > 0 || e_ev));
    chk("err_unexp", 128'(err_unexp), 128'(m_err));
    if (eng_valid) begin n_issue++; sel_log.push_back(int'(eng_sel)); end
    if (chk_route && res_valid != '0) begin
      want_rv = N_REQ'(1) << iss_sel[nxt_res];
      chk("route_data", 128'(res_data), 128'(nxt_res));
      chk("route_sel",  128'(res_valid), 128'(want_rv));
      nxt_res++;
      n_res++;
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en) do_cmp();
      end
    join_none

    cyc(1); chk_en = 1'b1; cyc(2);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_eng_valid", 128'(eng_valid), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));

    // stray results: cycle 5 is inside the flush window, cycle 40 is not
    rst = 1'b0;
    cyc(5); man_v = 1'b1; cyc(1); man_v = 1'b0;
    chk("flush_no_err", 128'(err_unexp), 128'(0));
    cyc(34); man_v = 1'b1; cyc(1); man_v = 1'b0; cyc(1);
    chk("late_err", 128'(err_unexp), 128'(1));
    cyc(3);
    chk("err_sticky", 128'(err_unexp), 128'(1));
    rst = 1'b1; cyc(1);
    chk("err_cleared", 128'(err_unexp), 128'(0));
    rst = 1'b0; cyc(16);

    // single requester, words 1.0..4.0
    eng_auto = 1'b1;
    req_data[127:0] = 128'h40800000_40400000_40000000_3f800000;
    req_valid = 3'b001;
    cyc(1);
    chk("single_eng_valid", 128'(eng_valid), 128'(1));
    chk("single_eng_sel", 128'(eng_sel), 128'(0));
    chk("single_eng_data", eng_data, 128'h40800000_40400000_40000000_3f800000);
    chk("single_ready_gap", 128'(req_ready), 128'(0));
    cyc(3);
    chk("single_ready_slot", 128'(req_ready), 128'(3'b001));
    cyc(16); req_valid = '0; cyc(30);

    // all three requesting, engine latency model, round-robin and routing
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(16);
    nxt_res = eng_idx; base = n_issue; base_res = n_res; sel_log.delete();
    chk_route = 1'b1;
    req_data = {128'hcccc0003_cccc0002_cccc0001_cccc0000,
                128'hbbbb0003_bbbb0002_bbbb0001_bbbb0000,
                128'haaaa0003_aaaa0002_aaaa0001_aaaa0000};
    req_valid = 3'b111;
    cyc(48); req_valid = '0; cyc(40);
    chk_route = 1'b0;
    if (sel_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 128'(sel_log[i]), 128'(i % 3));
    end else chk("rr_order_count", 128'(sel_log.size()), 128'(6));
    chk("rr_issues", 128'(n_issue - base), 128'(12));
    chk("rr_results", 128'(n_res - base_res), 128'(12));

    // stalled engine: FIFO fills at TAG_DEPTH, one pop frees one slot
    eng_auto = 1'b0; base = n_issue;
    req_valid = 3'b111;
    cyc(60);
    chk("stall_grants", 128'(n_issue - base), 128'(8));
    chk("stall_ready", 128'(req_ready), 128'(0));
    man_v = 1'b1; cyc(1); man_v = 1'b0;
    cyc(5);
    chk("stall_regrant", 128'(n_issue - base), 128'(9));
    cyc(8);
    chk("stall_refull", 128'(n_issue - base), 128'(9));

    // reset with tags outstanding
    rst = 1'b1; cyc(1);
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_res_valid", 128'(res_valid), 128'(0));
    chk("mid_rst_eng_data", eng_data, 128'(0));
    rst = 1'b0; cyc(1);
    chk("restart_valid", 128'(eng_valid), 128'(1));
    chk("restart_sel", 128'(eng_sel), 128'(0));
    man_v = 1'b1; cyc(8); man_v = 1'b0;
    chk("restart_no_err", 128'(err_unexp), 128'(0));
    cyc(20); req_valid = '0; cyc(4);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
